// File: rtl/sync_axis_fifo_ram.sv
// Single-clock simple dual-port RAM with a registered, enabled read port.
// The read register doubles as the FIFO output data register.
module sync_axis_fifo_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on storage or read data so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_axis_fifo.sv
// Synchronous AXI-Stream FIFO: RAM-backed storage plus one output register,
// giving FIFO_DEPTH+1 words of capacity and registered status flags.
module sync_axis_fifo #(
  parameter int FIFO_WIDTH             = 64,
  parameter int FIFO_DEPTH             = 8,
  parameter int ALMOST_FULL_THRESHOLD  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [FIFO_WIDTH-1:0]         s_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [FIFO_WIDTH-1:0]         m_axis_tdata,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          full,
  output logic                          almost_full,
  output logic                          empty,
  output logic                          almost_empty
);

  localparam int ADDRESS_WIDTH = $clog2(FIFO_DEPTH);
  localparam int PTR_WIDTH     = ADDRESS_WIDTH + 1;

  localparam logic [PTR_WIDTH-1:0] ONE        = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] FULL_LEVEL = PTR_WIDTH'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH-1:0] AF_LEVEL   = PTR_WIDTH'(ALMOST_FULL_THRESHOLD);
  localparam logic [PTR_WIDTH-1:0] AE_LEVEL   = PTR_WIDTH'(ALMOST_EMPTY_THRESHOLD);

  // Handshake: a transfer happens on a rising edge exactly when valid and
  // ready are both 1; valid never waits on ready, and data/valid hold while
  // valid=1 and ready=0.

  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr_next, rd_ptr_next, level_next;
  logic                 wr, rd;

  assign s_axis_tready = !full && !reset;
  assign wr = s_axis_tvalid && s_axis_tready;
  // The output register loads from memory whenever it is free or being drained.
  assign rd = !empty && (!m_axis_tvalid || m_axis_tready);

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (wr) begin
      wr_ptr_next = wr_ptr + ONE;
    end
    if (rd) begin
      rd_ptr_next = rd_ptr + ONE;
    end
    // The wrap bit makes the pointer difference the exact memory occupancy.
    level_next = wr_ptr_next - rd_ptr_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      m_axis_tvalid <= 1'b0;
      full          <= 1'b0;
      almost_full   <= 1'b0;
      empty         <= 1'b1;
      almost_empty  <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      level        <= level_next;
      full         <= (level_next == FULL_LEVEL);
      almost_full  <= (level_next >= AF_LEVEL);
      empty        <= (level_next == '0);
      almost_empty <= (level_next <= AE_LEVEL);
      if (rd) begin
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  sync_axis_fifo_ram #(
    .WIDTH      (FIFO_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (ADDRESS_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr),
    .wr_addr (wr_ptr[ADDRESS_WIDTH-1:0]),
    .wr_data (s_axis_tdata),
    .rd_en   (rd),
    .rd_addr (rd_ptr[ADDRESS_WIDTH-1:0]),
    .rd_data (m_axis_tdata)
  );

endmodule

// File: tb/tb_sync_axis_fifo.sv
// Bench for sync_axis_fifo: cycle-level queue model plus an in-order stream
// scoreboard, driven by directed sequences and random valid/ready traffic.
module tb_sync_axis_fifo;

  localparam int W  = 64;
  localparam int D  = 8;
  localparam int AF = D - 2;
  localparam int AE = 2;

  logic                 clk;
  logic                 reset;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [W-1:0]         s_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [W-1:0]         m_axis_tdata;
  logic [$clog2(D):0]   level;
  logic                 full, almost_full, empty, almost_empty;

  sync_axis_fifo #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .level         (level),
    .full          (full),
    .almost_full   (almost_full),
    .empty         (empty),
    .almost_empty  (almost_empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // model and scoreboard state
  logic [W-1:0] mem_q[$];
  logic [W-1:0] exp_q[$];
  bit           mdl_valid;
  logic [W-1:0] mdl_data;
  int           checks;
  int           failures;
  int           in_count;
  int           out_count;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int lvl;
    lvl = mem_q.size();
    check("level", W'(level), W'(lvl));
    check("empty", W'(empty), W'(lvl == 0));
    check("full", W'(full), W'(lvl == D));
    check("almost_full", W'(almost_full), W'(lvl >= AF));
    check("almost_empty", W'(almost_empty), W'(lvl <= AE));
    check("s_tready", W'(s_axis_tready), W'(lvl != D));
    check("m_tvalid", W'(m_axis_tvalid), W'(mdl_valid));
    if (mdl_valid) check("m_tdata", m_axis_tdata, mdl_data);
  endtask

  // One clock: inputs already driven after a falling edge.
  task automatic step();
    bit wr, rd;
    wr = s_axis_tvalid && (mem_q.size() != D);
    rd = (mem_q.size() != 0) && (!mdl_valid || m_axis_tready);
    if (m_axis_tvalid && m_axis_tready) begin
      check("stream_order", m_axis_tdata, exp_q.pop_front());
      out_count++;
    end
    @(posedge clk);
    if (rd) begin
      mdl_data  = mem_q.pop_front();
      mdl_valid = 1'b1;
    end else if (m_axis_tready) begin
      mdl_valid = 1'b0;
    end
    if (wr) begin
      mem_q.push_back(s_axis_tdata);
      exp_q.push_back(s_axis_tdata);
      in_count++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit tv, input logic [W-1:0] td, input bit rdy);
    s_axis_tvalid = tv;
    s_axis_tdata  = td;
    m_axis_tready = rdy;
  endtask

  // Assert reset between edges, check the asynchronous clear, then release.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("rst_level", W'(level), 0);
    check("rst_m_tvalid", W'(m_axis_tvalid), 0);
    check("rst_s_tready", W'(s_axis_tready), 0);
    check("rst_empty", W'(empty), 1);
    check("rst_almost_empty", W'(almost_empty), 1);
    check("rst_full", W'(full), 0);
    check("rst_almost_full", W'(almost_full), 0);
    mem_q.delete();
    exp_q.delete();
    mdl_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_s_tready", W'(s_axis_tready), 1);
    in_count  = 0;
    out_count = 0;
  endtask

  initial begin
    int max_lvl;
    int took;
    logic [$clog2(D):0] steady_lvl;

    checks = 0;
    failures = 0;
    in_count = 0;
    out_count = 0;
    mdl_valid = 1'b0;
    mdl_data = '0;
    drive(1'b0, '0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    pulse_reset();
    @(negedge clk);
    check_outputs();

    // single word 0xA5: visible one edge after acceptance, for one cycle
    drive(1'b1, W'(64'hA5), 1'b1);
    step();
    check("a5_not_fallthrough", W'(m_axis_tvalid), 0);
    drive(1'b0, '0, 1'b1);
    step();
    check("a5_valid", W'(m_axis_tvalid), 1);
    check("a5_data", m_axis_tdata, W'(64'hA5));
    step();
    check("a5_one_cycle", W'(m_axis_tvalid), 0);
    check("a5_empty_again", W'(empty), 1);

    // fill with output stalled: 9 words accepted, word 9 left offered
    in_count = 0;
    out_count = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, W'(in_count), 1'b0);
      step();
    end
    check("fill_accepted", W'(in_count), 9);
    check("fill_level", W'(level), W'(D));
    check("fill_full", W'(full), 1);
    check("fill_tready", W'(s_axis_tready), 0);

    // drain from full while word 9 keeps being offered
    max_lvl = 0;
    for (int c = 0; c < 40 && out_count < 10; c++) begin
      drive(in_count < 10, W'(in_count), 1'b1);
      step();
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    check("drain_count", W'(out_count), 10);
    check("drain_level_bound", W'(max_lvl <= D), 1);

    // steady state: both sides always ready
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, {$urandom, $urandom}, 1'b1);
      step();
    end
    steady_lvl = level;
    took = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, {$urandom, $urandom}, 1'b1);
      if (m_axis_tvalid && m_axis_tready) took++;
      step();
      check("steady_level", W'(level), W'(steady_lvl));
    end
    check("steady_throughput", W'(took), 20);
    drive(1'b0, '0, 1'b1);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();

    // random traffic, 1000 words
    in_count = 0;
    out_count = 0;
    for (int c = 0; c < 20000 && out_count < 1000; c++) begin
      drive((in_count < 1000) && ($urandom_range(0, 1) == 1), {$urandom, $urandom},
            $urandom_range(0, 1) == 1);
      step();
    end
    check("rand_in_count", W'(in_count), 1000);
    check("rand_out_count", W'(out_count), 1000);

    // mid-stream reset with 5 words in memory
    drive(1'b0, '0, 1'b1);
    for (int c = 0; c < 4; c++) step();
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, {$urandom, $urandom}, 1'b0);
      step();
    end
    check("pre_reset_level", W'(level), 5);
    drive(1'b0, '0, 1'b1);
    pulse_reset();
    for (int c = 0; c < 5; c++) begin
      step();
      check("no_stale_valid", W'(m_axis_tvalid), 0);
    end
    drive(1'b1, W'(64'h1234), 1'b1);
    step();
    drive(1'b0, '0, 1'b1);
    step();
    check("post_reset_data", m_axis_tdata, W'(64'h1234));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_axis_fifo.md
SYNC_AXIS_FIFO -- requirements
Module: sync_axis_fifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 64: data width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: memory words; power of two, at least 4.
REQ-003 SHALL have parameter ALMOST_FULL_THRESHOLD, default FIFO_DEPTH-2: almost_full asserts when level is at least this value.
REQ-004 SHALL have parameter ALMOST_EMPTY_THRESHOLD, default 2: almost_empty asserts when level is at most this value.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port s_axis_tvalid, input, 1 bit: sink word valid.
REQ-008 SHALL have port s_axis_tready, output, 1 bit: sink can accept a word.
REQ-009 SHALL have port s_axis_tdata, input, FIFO_WIDTH bits: sink data.
REQ-010 SHALL have port m_axis_tvalid, output, 1 bit: source word valid.
REQ-011 SHALL have port m_axis_tready, input, 1 bit: downstream accepts the word.
REQ-012 SHALL have port m_axis_tdata, output, FIFO_WIDTH bits: source data, registered.
REQ-013 SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: words held in memory, excluding the output register.
REQ-014 SHALL have ports full, almost_full, empty and almost_empty, each an output of 1 bit: registered status flags derived from level.

Function
REQ-015 Write pointer and read pointer SHALL each be clog2(FIFO_DEPTH)+1 bits wide, with the MSB acting as the wrap bit; addresses are the lower bits and wrap modulo FIFO_DEPTH.
REQ-016 A write SHALL occur exactly when s_axis_tvalid and s_axis_tready are both 1; s_axis_tready SHALL equal not-full.
REQ-017 An internal read SHALL occur when the FIFO is not empty and the output register can load, i.e. m_axis_tvalid is 0 or m_axis_tready is 1.
REQ-018 On an internal read, m_axis_tdata SHALL load from memory and m_axis_tvalid SHALL become 1.
REQ-019 With no internal read, m_axis_tvalid SHALL clear when m_axis_tready is 1; otherwise m_axis_tvalid and m_axis_tdata SHALL hold.
REQ-020 Latency: a word accepted on edge k into an empty FIFO with an idle output SHALL present m_axis_tvalid=1 after edge k+1; there is no same-cycle fall-through.
REQ-021 Total capacity SHALL be FIFO_DEPTH+1 words (memory plus output register).
REQ-022 A simultaneous write and read SHALL leave level unchanged; write only SHALL add 1; read only SHALL subtract 1.
REQ-023 At full, s_axis_tready SHALL be 0 and no write occurs, even if a read happens in the same cycle; tready reasserts the cycle after level drops.
REQ-024 At empty, no internal read SHALL occur; a write in that cycle SHALL become readable in the next cycle.
REQ-025 The flags SHALL be updated on the same edge as level: full when level=FIFO_DEPTH, empty when level=0, plus the threshold compares for almost_full and almost_empty.
REQ-026 Holding m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0 (AXI-Stream rule) SHALL be guaranteed.

Reset
REQ-027 Reset SHALL clear both pointers, level and m_axis_tvalid to 0, set empty=1 and almost_empty=1, and set full=0 and almost_full=0.
REQ-028 s_axis_tready SHALL be 0 while reset is 1 and SHALL be 1 in the first cycle after release.
REQ-029 Memory contents and m_axis_tdata are not reset.
REQ-030 Reset asserted mid-stream SHALL discard all stored words; no word is emitted after release until new data is written.

Structure
REQ-031 No shared package SHALL be used; ADDRESS_WIDTH=clog2(FIFO_DEPTH) is a local parameter.
REQ-032 Storage SHALL be one sub-module, sync_axis_fifo_ram: a single-clock simple dual-port RAM with registered read, inferable as block RAM.
REQ-033 Pointer, level, flag and output-register logic SHALL reside in sync_axis_fifo.

Verification
REQ-034 Reset, then one write of 0xA5 at edge k, m_axis_tready=1 -> m_axis_tvalid=1 with data 0xA5 after edge k+1, one cycle only; empty returns to 1.
REQ-035 Default parameters, m_axis_tready=0, continuous writes 0..9 -> 9 words accepted; full=1 and s_axis_tready=0 with word 9 still offered; almost_full from level 6.
REQ-036 From full, m_axis_tready=1 while s_axis_tvalid stays 1 -> output 0..8 in order, then 9; level never exceeds 8.
REQ-037 Random tvalid/tready at 50%, 1000 words -> output sequence equals input sequence; pointers wrap many times.
REQ-038 Steady state, both sides always ready -> one word per cycle, level constant.
REQ-039 Reset pulse with level=5 -> level=0 and m_axis_tvalid=0 immediately; no stale data appears after release.
